fifo_axis_framer: RTL and testbench

FIFO_AXIS_FRAMER -- requirements
Module: fifo_axis_framer

---
 rtl/fifo_axis_framer_pkg.sv | 24 ++
 rtl/axis_output_stage.sv | 46 ++++
 rtl/fifo_axis_framer.sv | 107 ++++++++++
 tb/tb_fifo_axis_framer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_framer_pkg.sv
// Shared constants and helpers for the FIFO-to-AXI-Stream framer and its FIFO.
package fifo_axis_framer_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_FRAME_LEN = 16;
    localparam int DEFAULT_TIMEOUT   = 64;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_output_stage.sv
// Registered AXI-Stream output slice: holds TDATA/TLAST until the downstream accepts.
module axis_output_stage
    import fifo_axis_framer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    output logic             o_tlast,
    input  logic             i_tready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;

    // A beat transfers on a rising edge where o_tvalid & i_tready; once o_tvalid
    // rises, o_tdata/o_tlast stay frozen and o_tvalid stays high until that edge.
    // The slice loads a new word whenever it is empty or its beat is leaving.
    assign o_ready = ~r_valid | i_tready;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            r_last  <= i_valid & i_last;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_tdata  = r_data;
    assign o_tvalid = r_valid;
    assign o_tlast  = r_last;

endmodule

// File: rtl/fifo_axis_framer.sv
// Pops words from a show-ahead FIFO and frames them into AXI-Stream packets of
// FRAME_LEN beats, closing a partial frame after TIMEOUT idle cycles.
module fifo_axis_framer
    import fifo_axis_framer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] FIFO_DOUT,
    input  logic             FIFO_NOT_EMPTY,
    output logic             FIFO_RE,
    output logic [WIDTH-1:0] M_TDATA,
    output logic             M_TVALID,
    input  logic             M_TREADY,
    output logic             M_TLAST,
    output logic [15:0]      FRAME_COUNT,
    output logic [15:0]      SHORT_COUNT
);

    localparam int                IDLE_W    = clogb2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT - 1);
    localparam logic [15:0]       LAST_BEAT = 16'(FRAME_LEN - 1);

    logic              r_hold_valid;
    logic [WIDTH-1:0]  r_hold_data;
    logic [15:0]       r_beat_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [15:0]       r_frame_count;
    logic [15:0]       r_short_count;

    logic w_stage_ready;
    logic w_last_beat;
    logic w_expired;
    logic w_release;
    logic w_tlast;
    logic w_short;

    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_expired   = r_hold_valid & (r_idle_cnt == IDLE_MAX);

    // The held word waits for a successor so it knows whether it ends the frame,
    // unless the frame is already full or the FIFO has been idle too long.
    assign w_release = r_hold_valid & w_stage_ready &
                       (FIFO_NOT_EMPTY | w_last_beat | w_expired);
    assign w_tlast   = w_last_beat | (w_expired & ~FIFO_NOT_EMPTY);
    assign w_short   = w_expired & ~FIFO_NOT_EMPTY & ~w_last_beat;

    assign FIFO_RE = RESETN & FIFO_NOT_EMPTY & (~r_hold_valid | w_release);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_hold_valid  <= 1'b0;
            r_hold_data   <= '0;
            r_beat_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_frame_count <= '0;
            r_short_count <= '0;
        end else begin
            if (FIFO_RE) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= FIFO_DOUT;
            end else if (w_release) begin
                r_hold_valid <= 1'b0;
            end

            if (w_release) begin
                r_beat_cnt <= w_tlast ? 16'd0 : r_beat_cnt + 16'd1;
            end

            // Saturates at expiry so a stalled output keeps the timeout asserted.
            if (!r_hold_valid || FIFO_NOT_EMPTY || w_release) begin
                r_idle_cnt <= '0;
            end else if (!w_expired) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (M_TVALID && M_TREADY && M_TLAST) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_release && w_short) begin
                r_short_count <= r_short_count + 16'd1;
            end
        end
    end

    axis_output_stage #(
        .WIDTH (WIDTH)
    ) u_out (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .i_valid  (w_release),
        .i_data   (r_hold_data),
        .i_last   (w_tlast),
        .o_ready  (w_stage_ready),
        .o_tdata  (M_TDATA),
        .o_tvalid (M_TVALID),
        .o_tlast  (M_TLAST),
        .i_tready (M_TREADY)
    );

    assign FRAME_COUNT = r_frame_count;
    assign SHORT_COUNT = r_short_count;

endmodule

// File: tb/tb_fifo_axis_framer.sv
// Bench for fifo_axis_framer: FIFO model, directed scenarios and random bursts
// checked against a frame-position model of the expected beats.
module tb_fifo_axis_framer;

    localparam int W  = 8;
    localparam int FL = 4;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic [W-1:0]  FIFO_DOUT = '0;
    logic          FIFO_NOT_EMPTY = 1'b0;
    logic          FIFO_RE;
    logic [W-1:0]  M_TDATA;
    logic          M_TVALID;
    logic          M_TREADY = 1'b0;
    logic          M_TLAST;
    logic [15:0]   FRAME_COUNT;
    logic [15:0]   SHORT_COUNT;

    // clock / reset
    always #5 CLK = ~CLK;

    fifo_axis_framer #(
        .WIDTH     (W),
        .FRAME_LEN (FL),
        .TIMEOUT   (TO)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .FIFO_DOUT      (FIFO_DOUT),
        .FIFO_NOT_EMPTY (FIFO_NOT_EMPTY),
        .FIFO_RE        (FIFO_RE),
        .M_TDATA        (M_TDATA),
        .M_TVALID       (M_TVALID),
        .M_TREADY       (M_TREADY),
        .M_TLAST        (M_TLAST),
        .FRAME_COUNT    (FRAME_COUNT),
        .SHORT_COUNT    (SHORT_COUNT)
    );

    // scoreboard state
    logic [W-1:0] fifo_q[$];
    logic [W:0]   exp_q[$];
    int           frame_pos   = 0;
    int           exp_frames  = 0;
    int           exp_shorts  = 0;
    int           n_tests     = 0;
    int           n_fail      = 0;
    int           n_acc       = 0;
    int           rdy_mode    = 0;
    logic         rdy_tog     = 1'b0;
    logic         prev_stall  = 1'b0;
    logic [W-1:0] prev_data   = '0;
    logic         prev_last   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        FIFO_NOT_EMPTY = (fifo_q.size() != 0);
        FIFO_DOUT      = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // Expected framing: a beat ends its frame when it fills the frame or is
    // the last word before the source goes quiet long enough to time out.
    task automatic push_word(input logic [W-1:0] d, input bit burst_end);
        logic last;
        fifo_q.push_back(d);
        last = (frame_pos == FL - 1) || burst_end;
        exp_q.push_back({last, d});
        if (burst_end && frame_pos != FL - 1) exp_shorts++;
        frame_pos = last ? 0 : frame_pos + 1;
    endtask

    task automatic monitor();
        logic [W:0] e;
        if (prev_stall)
            check("stall_hold", 32'({M_TVALID, M_TLAST, M_TDATA}),
                  32'({1'b1, prev_last, prev_data}));
        if (M_TVALID && M_TREADY) begin
            check("extra_beat", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", 32'({M_TLAST, M_TDATA}), 32'(e));
                if (e[W]) exp_frames++;
            end
            n_acc++;
        end
        prev_stall = M_TVALID & ~M_TREADY;
        prev_data  = M_TDATA;
        prev_last  = M_TLAST;
    endtask

    // One clock cycle: drive at negedge, sample before the edge, pop after it.
    task automatic tick();
        logic re;
        case (rdy_mode)
            0: M_TREADY = 1'b1;
            1: begin rdy_tog = ~rdy_tog; M_TREADY = rdy_tog; end
            default: M_TREADY = 1'($urandom_range(0, 1));
        endcase
        refresh();
        #1;
        re = FIFO_RE;
        check("re_gate", 32'(FIFO_RE & ~(FIFO_NOT_EMPTY & RESETN)), 32'd0);
        if (RESETN) monitor();
        @(posedge CLK);
        #1;
        if (re && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
        @(negedge CLK);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frames"}, 32'(FRAME_COUNT), 32'(exp_frames));
        check({tag, "_shorts"}, 32'(SHORT_COUNT), 32'(exp_shorts));
    endtask

    task automatic check_reset_outputs();
        check("rst_tvalid", 32'(M_TVALID), 32'd0);
        check("rst_tlast",  32'(M_TLAST),  32'd0);
        check("rst_tdata",  32'(M_TDATA),  32'd0);
        check("rst_frames", 32'(FRAME_COUNT), 32'd0);
        check("rst_shorts", 32'(SHORT_COUNT), 32'd0);
        check("rst_re",     32'(FIFO_RE),  32'd0);
    endtask

    initial begin
        @(negedge CLK);
        RESETN = 1'b0;
        repeat (3) tick();
        fifo_q.push_back(8'h55);
        tick();
        check_reset_outputs();
        fifo_q.delete();
        refresh();
        RESETN = 1'b1;
        tick();

        // Preloaded 8 words, downstream always ready: two full frames
        for (int i = 1; i <= 8; i++) push_word(8'(i), i == 8);
        drain(100);
        check_counts("preload");

        // Two words then silence: second word closes a short frame
        push_word(8'hA0, 1'b0);
        push_word(8'hA1, 1'b1);
        drain(100);
        check_counts("short");

        // Alternating ready with stalls
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i), i == 7);
        drain(100);
        check_counts("stall");
        rdy_mode = 0;

        // Successor arrives exactly when the idle count reaches its limit
        push_word(8'hB0, 1'b0);
        tick();
        repeat (TO - 1) tick();
        push_word(8'hB1, 1'b1);
        drain(100);
        check_counts("edge");

        // Random bursts with short gaps, random downstream ready
        rdy_mode = 2;
        for (int b = 0; b < 12; b++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                push_word(8'($urandom_range(0, 255)), i == len - 1);
                tick();
                repeat ($urandom_range(0, 2)) tick();
            end
            drain(200);
        end
        check_counts("random");
        rdy_mode = 0;

        // Reset in the middle of a frame
        n_acc = 0;
        for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i), i == 3);
        for (int k = 0; k < 20 && n_acc < 2; k++) tick();
        check("rst_mid_acc", 32'(n_acc), 32'd2);
        RESETN = 1'b0;
        tick();
        check_reset_outputs();
        fifo_q.delete();
        exp_q.delete();
        frame_pos  = 0;
        exp_frames = 0;
        exp_shorts = 0;
        prev_stall = 1'b0;
        RESETN = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i), i == 3);
        drain(100);
        check("post_rst_frames", 32'(FRAME_COUNT), 32'd1);
        check_counts("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
